// File: rtl/soc_ahb_pkg.sv
// Shared AHB-Lite types and helpers for the FPGA-to-SoC master arbiter.
// Optional data-phase timeout is enabled with SOC_AHB_ARB_TIMEOUT_EN.
package soc_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } arb_state_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEF     = 4'b0011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [3:0] be_from_size(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (size == SZ_BYTE): be = 4'b0001 << addr_lo;
      (size == SZ_HALF): be = addr_lo[1] ? 4'b1100 : 4'b0011;
      (size == SZ_WORD): be = 4'b1111;
      default:           be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic size_ok(
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): ok = 1'b1;
      (size == SZ_HALF): ok = !addr_lo[0];
      (size == SZ_WORD): ok = (addr_lo == 2'b00);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/soc_ahb_rr_arb.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Produces one-hot grant, its index and an any-request flag.
module soc_ahb_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j[IW-1:0]]) begin
        any              = 1'b1;
        gnt[j[IW-1:0]]   = 1'b1;
        idx              = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/soc_fpga_ahb_master_arb.sv
// Round-robin AHB-Lite single-beat master sharing the SoC S0 slave port.
// Define SOC_AHB_ARB_TIMEOUT_EN to bound ADDR/DATA wait states.
module soc_fpga_ahb_master_arb
  import soc_ahb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [2*NUM_REQ-1:0]  req_size,
  input  logic [AW*NUM_REQ-1:0] req_addr,
  input  logic [DW*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_rdata,
  output logic [AW-1:0]         haddr,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [3:0]            hprot,
  output logic [DW-1:0]         hwdata,
  output logic [3:0]            hwbe,
  output logic                  hsel,
  output logic                  hmastlock,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DW-1:0]         hrdata
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e state, state_nxt;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      cidx;
  logic [IW-1:0]      rsp_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               any;

  logic          cw;
  logic [1:0]    csz;
  logic [AW-1:0] caddr;
  logic [DW-1:0] cwdata;
  logic [3:0]    cbe;

  logic [1:0]    gsz;
  logic [AW-1:0] gaddr;
  logic          glegal;

  logic accept;
  logic done;
  logic done_err;
  logic tmo;

  soc_ahb_rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign gsz    = req_size[gidx*2 +: 2];
  assign gaddr  = req_addr[gidx*AW +: AW];
  assign glegal = size_ok(gsz, gaddr[1:0]);

  // Illegal requests answer straight from IDLE, so route to the live grant.
  assign rsp_idx = (state == ST_IDLE) ? gidx : cidx;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any && !hrst) begin
          req_ready = gnt;
          accept    = 1'b1;
          if (glegal) begin
            state_nxt = ST_ADDR;
          end else begin
            done     = 1'b1;
            done_err = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_nxt = ST_DATA;
        end else if (tmo) begin
          done      = 1'b1;
          done_err  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (hready) begin
          done      = 1'b1;
          done_err  = hresp;
          state_nxt = ST_IDLE;
        end else if (hresp) begin
          state_nxt = ST_ERR;
        end else if (tmo) begin
          done      = 1'b1;
          done_err  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (hready) begin
          done      = 1'b1;
          done_err  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cidx      <= '0;
      cw        <= 1'b0;
      csz       <= SZ_WORD;
      caddr     <= '0;
      cwdata    <= '0;
      cbe       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        ptr <= (gidx == IW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end
      if (accept && glegal) begin
        cidx   <= gidx;
        cw     <= req_write[gidx];
        csz    <= gsz;
        caddr  <= gaddr;
        cwdata <= req_wdata[gidx*DW +: DW];
        cbe    <= be_from_size(gsz, gaddr[1:0]);
      end
      if (done) begin
        rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << rsp_idx;
        rsp_err   <= done_err;
        if (!done_err && !cw) rsp_rdata <= hrdata;
      end
    end
  end

`ifdef SOC_AHB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tcnt;
  logic          stall;

  assign stall = ((state == ST_ADDR) || (state == ST_DATA)) && !hready;
  assign tmo   = stall && (tcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge hclk) begin
    if (hrst || (state == ST_IDLE)) begin
      tcnt <= '0;
    end else if (stall) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  assign htrans    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsel      = (state == ST_ADDR);
  assign haddr     = caddr;
  assign hwrite    = cw;
  assign hsize     = {1'b0, csz};
  assign hwbe      = cbe;
  assign hwdata    = cwdata;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DEF;
  assign hmastlock = 1'b0;

endmodule
